multi_fan_ctrl: RTL

MULTI_FAN_CTRL -- requirements
Module: multi_fan_ctrl

---
 rtl/fan_pkg.sv | 47 ++++
 rtl/fan_tach_mon.sv | 103 ++++++++++
 rtl/multi_fan_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fan_pkg.sv
// Shared definitions for the multi-channel fan controller: channel states,
// automatic duty levels and the temperature thresholds behind them.
package fan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPINUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_STALL  = 2'd3
  } fan_state_t;

  localparam logic [6:0] DUTY_20  = 7'd20;
  localparam logic [6:0] DUTY_40  = 7'd40;
  localparam logic [6:0] DUTY_60  = 7'd60;
  localparam logic [6:0] DUTY_80  = 7'd80;
  localparam logic [6:0] DUTY_100 = 7'd100;

  localparam logic [8:0] OFS_100 = 9'd16;
  localparam logic [8:0] OFS_80  = 9'd12;
  localparam logic [8:0] OFS_60  = 9'd8;
  localparam logic [8:0] OFS_40  = 9'd4;

  localparam logic [8:0] ABS_100 = 9'd72;
  localparam logic [8:0] ABS_80  = 9'd66;
  localparam logic [8:0] ABS_60  = 9'd60;
  localparam logic [8:0] ABS_40  = 9'd54;

  // Sums are widened to 9 bits so a hot inlet cannot wrap the offset compare.
  function automatic logic [6:0] auto_duty(input logic [7:0] in_t, input logic [7:0] out_t);
    logic [8:0] in9;
    logic [8:0] out9;
    in9  = {1'b0, in_t};
    out9 = {1'b0, out_t};
    if ((out9 > in9 + OFS_100) || (out9 > ABS_100)) begin
      auto_duty = DUTY_100;
    end else if ((out9 > in9 + OFS_80) || (out9 > ABS_80)) begin
      auto_duty = DUTY_80;
    end else if ((out9 > in9 + OFS_60) || (out9 > ABS_60)) begin
      auto_duty = DUTY_60;
    end else if ((out9 > in9 + OFS_40) || (out9 > ABS_40)) begin
      auto_duty = DUTY_40;
    end else begin
      auto_duty = DUTY_20;
    end
  endfunction

endpackage

// File: rtl/fan_tach_mon.sv
// Per-fan tach monitor: input synchroniser, windowed rising-edge counter and
// the IDLE/SPINUP/RUN/STALL health state machine.
module fan_tach_mon
  import fan_pkg::*;
#(
  parameter int STALL_MIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tach,
  input  logic        win_end,
  input  logic        duty_zero,
  output logic [15:0] rpm_cnt,
  output logic        stall
);

  logic        sync1_r;
  logic        sync2_r;
  logic        tach_d_r;
  logic        rise_s;
  logic        low_cnt_s;
  logic [15:0] edge_cnt_r;
  logic [15:0] rpm_cnt_r;
  fan_state_t  state_r;
  logic        sp_seen_r;
  logic        stall_r;

  assign rise_s    = sync2_r & ~tach_d_r;
  assign low_cnt_s = (edge_cnt_r < 16'(STALL_MIN));
  assign rpm_cnt   = rpm_cnt_r;
  assign stall     = stall_r;

  // Synchronise tach and count rising edges; an edge on the window-end cycle opens the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      tach_d_r   <= 1'b0;
      edge_cnt_r <= 16'd0;
      rpm_cnt_r  <= 16'd0;
    end else begin
      sync1_r  <= tach;
      sync2_r  <= sync1_r;
      tach_d_r <= sync2_r;
      if (win_end) begin
        rpm_cnt_r  <= edge_cnt_r;
        edge_cnt_r <= rise_s ? 16'd1 : 16'd0;
      end else if (rise_s && (edge_cnt_r != 16'hFFFF)) begin
        edge_cnt_r <= edge_cnt_r + 16'd1;
      end else begin
        edge_cnt_r <= edge_cnt_r;
      end
    end
  end

  // Health FSM; SPINUP waits for a second window end so the fan gets one full grace window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      sp_seen_r <= 1'b0;
      stall_r   <= 1'b0;
    end else if (duty_zero) begin
      state_r   <= ST_IDLE;
      sp_seen_r <= 1'b0;
      stall_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r   <= ST_SPINUP;
          sp_seen_r <= 1'b0;
          stall_r   <= 1'b0;
        end
        ST_SPINUP: begin
          if (win_end) begin
            if (sp_seen_r) begin
              state_r <= ST_RUN;
            end else begin
              sp_seen_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (win_end && low_cnt_s) begin
            state_r <= ST_STALL;
            stall_r <= 1'b1;
          end
        end
        ST_STALL: begin
          if (win_end && !low_cnt_s) begin
            state_r <= ST_RUN;
            stall_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          sp_seen_r <= 1'b0;
          stall_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_fan_ctrl.sv
// Multi-channel fan controller: shared PWM period, tach window and duty ramp,
// with per-channel PWM generation and tach health monitoring.
module multi_fan_ctrl
  import fan_pkg::*;
#(
  parameter int SYS_FREQ     = 100_000_000,
  parameter int PWM_FREQ     = 20_000,
  parameter int N_FAN        = 4,
  parameter int RAMP_STEP    = 1,
  parameter int START_DUTY   = 20,
  parameter int TACH_WIN_CYC = SYS_FREQ,
  parameter int STALL_MIN    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           min_in_temp,
  input  logic [7:0]           max_out_temp,
  input  logic                 manual,
  input  logic [6:0]           manual_duty,
  input  logic [N_FAN-1:0]     tach,
  output logic [N_FAN-1:0]     pwm,
  output logic [16*N_FAN-1:0]  rpm_cnt,
  output logic [N_FAN-1:0]     stall,
  output logic                 alarm
);

  localparam int PERIOD = SYS_FREQ / PWM_FREQ;
  localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int CW     = $clog2(PERIOD + 1);
  localparam int WW     = (TACH_WIN_CYC > 1) ? $clog2(TACH_WIN_CYC) : 1;
  localparam logic [6:0] STEP = 7'(RAMP_STEP);

  logic [PW-1:0]    per_cnt_r;
  logic [WW-1:0]    win_cnt_r;
  logic             per_end_s;
  logic             win_end_s;
  logic [6:0]       cur_duty_r;
  logic [6:0]       target_s;
  logic [6:0]       next_duty_s;
  logic             duty_zero_s;
  logic [CW-1:0]    high_cnt_r [N_FAN];
  logic [N_FAN-1:0] pwm_r;
  logic [N_FAN-1:0] stall_s;
  logic             alarm_r;

  function automatic logic [CW-1:0] duty_to_high(input logic [6:0] d);
    logic [31:0] prod;
    prod = 32'(d) * 32'(PERIOD);
    return CW'(prod / 32'd100);
  endfunction

  assign per_end_s   = (per_cnt_r == PW'(PERIOD - 1));
  assign win_end_s   = (win_cnt_r == WW'(TACH_WIN_CYC - 1));
  assign duty_zero_s = (cur_duty_r == 7'd0);
  assign pwm         = pwm_r;
  assign stall       = stall_s;
  assign alarm       = alarm_r;

  // Target selection and one ramp step toward it.
  always_comb begin
    target_s    = manual ? ((manual_duty > 7'd100) ? 7'd100 : manual_duty)
                         : auto_duty(min_in_temp, max_out_temp);
    next_duty_s = cur_duty_r;
    if (target_s > cur_duty_r) begin
      if ((target_s - cur_duty_r) > STEP) begin
        next_duty_s = cur_duty_r + STEP;
      end else begin
        next_duty_s = target_s;
      end
    end else if (target_s < cur_duty_r) begin
      if ((cur_duty_r - target_s) > STEP) begin
        next_duty_s = cur_duty_r - STEP;
      end else begin
        next_duty_s = target_s;
      end
    end else begin
      next_duty_s = cur_duty_r;
    end
  end

  // Shared period/window counters and the duty register, which moves only at period end.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt_r  <= '0;
      win_cnt_r  <= '0;
      cur_duty_r <= 7'(START_DUTY);
      alarm_r    <= 1'b0;
    end else begin
      per_cnt_r  <= per_end_s ? '0 : per_cnt_r + PW'(1);
      win_cnt_r  <= win_end_s ? '0 : win_cnt_r + WW'(1);
      cur_duty_r <= per_end_s ? next_duty_s : cur_duty_r;
      alarm_r    <= |stall_s;
    end
  end

  // Per-channel high time is latched at period end so a new duty never cuts a pulse short.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_FAN; i++) begin
      if (rst) begin
        high_cnt_r[i] <= '0;
        pwm_r[i]      <= 1'b0;
      end else begin
        if (per_end_s) begin
          high_cnt_r[i] <= duty_to_high(stall_s[i] ? 7'd100 : next_duty_s);
        end
        pwm_r[i] <= (CW'(per_cnt_r) < high_cnt_r[i]);
      end
    end
  end

  for (genvar g = 0; g < N_FAN; g++) begin : g_fan
    fan_tach_mon #(
      .STALL_MIN (STALL_MIN)
    ) u_mon (
      .clk       (clk),
      .rst       (rst),
      .tach      (tach[g]),
      .win_end   (win_end_s),
      .duty_zero (duty_zero_s),
      .rpm_cnt   (rpm_cnt[16*g +: 16]),
      .stall     (stall_s[g])
    );
  end

endmodule
